// File: rtl/knn_pkg.sv
// Shared definitions for the KNN classifier pipeline: default widths,
// vote FSM state encodings and the per-class count width helper.
package knn_pkg;

    localparam int KNN_TYPE_W = 3;
    localparam int KNN_L      = 5;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] COUNT  = 2'd1;
    localparam logic [1:0] SELECT = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    // A count holds at most K, and first-occurrence positions use K as "not seen".
    function automatic int cnt_width(input int k);
        return $clog2(k + 1);
    endfunction

endpackage

// File: rtl/knn_type_counter.sv
// Per-class occurrence counters and first-occurrence positions for the vote stage,
// with a bulk clear, a single increment port and an asynchronous read port.
module knn_type_counter
    import knn_pkg::*;
#(
    parameter int TYPE_W = KNN_TYPE_W,
    parameter int K      = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    inc,
    input  logic [TYPE_W-1:0]       inc_type,
    input  logic [cnt_width(K)-1:0] inc_pos,
    input  logic [TYPE_W-1:0]       rd_type,
    output logic [cnt_width(K)-1:0] rd_count,
    output logic [cnt_width(K)-1:0] rd_first_pos
);

    localparam int T  = 1 << TYPE_W;
    localparam int CW = cnt_width(K);

    logic [CW-1:0] count     [T];
    logic [CW-1:0] first_pos [T];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < T; i++) begin
                count[i]     <= '0;
                first_pos[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < T; i++) begin
                count[i]     <= '0;
                first_pos[i] <= CW'(K);
            end
        end else if (inc) begin
            count[inc_type] <= count[inc_type] + CW'(1);
            // Only the first sighting of a class records its position.
            if (first_pos[inc_type] == CW'(K)) begin
                first_pos[inc_type] <= inc_pos;
            end
        end
    end

    assign rd_count     = count[rd_type];
    assign rd_first_pos = first_pos[rd_type];

endmodule

// File: rtl/knn_vote.sv
// Majority vote over the K nearest sorted labels; final stage of the KNN pipeline.
// Optional build macro KNN_VOTE_COUNT_OUT_EN adds the vote_count output.
module knn_vote
    import knn_pkg::*;
#(
    parameter int L      = KNN_L,
    parameter int TYPE_W = KNN_TYPE_W,
    parameter int K      = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_sort,
    input  logic [TYPE_W*(2**L)-1:0]   type_array_sorted,
    output logic [TYPE_W-1:0]          predicted_type,
    output logic                       valid_vote,
`ifdef KNN_VOTE_COUNT_OUT_EN
    output logic [cnt_width(K)-1:0]    vote_count,
`endif
    output logic                       busy
);

    localparam int N  = 2 ** L;
    localparam int CW = cnt_width(K);

    generate
        if (K < 1 || K > N) begin : g_bad_k
            $error("knn_vote: K must satisfy 1 <= K <= 2**L");
        end
        if (K < N) begin : g_upper
            logic unused_upper;
            assign unused_upper = ^type_array_sorted[TYPE_W*N-1:TYPE_W*K];
        end
    endgenerate

    logic [1:0]          state;
    logic                valid_sort_q;
    logic                start;
    logic [K*TYPE_W-1:0] latched;
    logic [CW-1:0]       idx;
    logic [TYPE_W-1:0]   cls;
    logic [CW-1:0]       best_count;
    logic [TYPE_W-1:0]   best_type;
    logic [CW-1:0]       best_pos;
    logic [TYPE_W-1:0]   cur_type;
    logic [CW-1:0]       rd_count;
    logic [CW-1:0]       rd_first_pos;
    logic                better;

    assign start    = valid_sort & ~valid_sort_q;
    assign busy     = (state != IDLE);
    assign cur_type = latched[int'(idx)*TYPE_W +: TYPE_W];

    // Equal counts fall back to the class seen nearest; empty classes never win ties.
    assign better = (rd_count > best_count) ||
                    ((rd_count == best_count) && (rd_count != '0) && (rd_first_pos < best_pos));

    knn_type_counter #(
        .TYPE_W (TYPE_W),
        .K      (K)
    ) u_counter (
        .clk          (clk),
        .rst          (rst),
        .clear        ((state == IDLE) && start),
        .inc          (state == COUNT),
        .inc_type     (cur_type),
        .inc_pos      (idx),
        .rd_type      (cls),
        .rd_count     (rd_count),
        .rd_first_pos (rd_first_pos)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            valid_sort_q   <= 1'b0;
            latched        <= '0;
            idx            <= '0;
            cls            <= '0;
            best_count     <= '0;
            best_type      <= '0;
            best_pos       <= '0;
            predicted_type <= '0;
            valid_vote     <= 1'b0;
        end else begin
            valid_sort_q <= valid_sort;
            valid_vote   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        latched    <= type_array_sorted[K*TYPE_W-1:0];
                        idx        <= '0;
                        cls        <= '0;
                        best_count <= '0;
                        best_type  <= '0;
                        best_pos   <= CW'(K);
                        state      <= COUNT;
                    end
                end
                COUNT: begin
                    idx <= idx + CW'(1);
                    if (idx == CW'(K - 1)) begin
                        state <= SELECT;
                    end
                end
                SELECT: begin
                    if (better) begin
                        best_count <= rd_count;
                        best_type  <= cls;
                        best_pos   <= rd_first_pos;
                    end
                    cls <= cls + TYPE_W'(1);
                    if (cls == '1) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    predicted_type <= best_type;
                    valid_vote     <= 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef KNN_VOTE_COUNT_OUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vote_count <= '0;
        end else if (state == DONE) begin
            vote_count <= best_count;
        end
    end
`endif

endmodule

// File: tb/tb_knn_vote.sv
// Directed self-checking bench for knn_vote with default parameters (K=5, TYPE_W=3, L=5).
// Checks vote_count as well when built with KNN_VOTE_COUNT_OUT_EN.
module tb_knn_vote;

    logic        clk;
    logic        rst;
    logic        valid_sort;
    logic [95:0] type_array_sorted;
    logic [2:0]  predicted_type;
    logic        valid_vote;
    logic        busy;
`ifdef KNN_VOTE_COUNT_OUT_EN
    logic [2:0]  vote_count;
`endif

    int checks = 0;
    int errors = 0;

    knn_vote #(
        .L      (5),
        .TYPE_W (3),
        .K      (5)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .valid_sort        (valid_sort),
        .type_array_sorted (type_array_sorted),
        .predicted_type    (predicted_type),
        .valid_vote        (valid_vote),
`ifdef KNN_VOTE_COUNT_OUT_EN
        .vote_count        (vote_count),
`endif
        .busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Entries 0..4 get the listed labels, every other entry gets fill.
    task automatic applyStimulus(input logic [2:0] t0, input logic [2:0] t1, input logic [2:0] t2,
                                 input logic [2:0] t3, input logic [2:0] t4, input logic [2:0] fill);
        logic [95:0] v;
        for (int i = 0; i < 32; i++) v[i*3 +: 3] = fill;
        v[2:0]   = t0;
        v[5:3]   = t1;
        v[8:6]   = t2;
        v[11:9]  = t3;
        v[14:12] = t4;
        type_array_sorted = v;
    endtask

    // Expects valid_sort to have been raised just before the next rising edge (edge 0).
    task automatic waitResult(input string tag, input logic [2:0] exp_type, input int exp_cnt);
        int n;
        n = 0;
        @(posedge clk);
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (valid_vote) break;
        end
        checkOutput({tag, "_latency"}, n, 14);
        checkOutput({tag, "_type"}, {29'd0, predicted_type}, {29'd0, exp_type});
`ifdef KNN_VOTE_COUNT_OUT_EN
        checkOutput({tag, "_count"}, {29'd0, vote_count}, exp_cnt);
`else
        if (exp_cnt < 0) $display("[TB] unexpected negative count for %s", tag);
`endif
        checkOutput({tag, "_busy_low"}, {31'd0, busy}, 0);
        @(posedge clk);
        #1;
        checkOutput({tag, "_pulse_width"}, {31'd0, valid_vote}, 0);
    endtask

    task automatic runVote(input string tag, input logic [2:0] exp_type, input int exp_cnt);
        @(negedge clk);
        valid_sort = 1'b1;
        waitResult(tag, exp_type, exp_cnt);
        @(negedge clk);
        valid_sort = 1'b0;
        @(negedge clk);
    endtask

    task automatic countPulses(input int cycles, output int pulses, output logic [2:0] last_type);
        pulses    = 0;
        last_type = '0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (valid_vote) begin
                pulses++;
                last_type = predicted_type;
            end
        end
    endtask

    initial begin
        int          pulses;
        logic [2:0]  seen;

        rst        = 1'b1;
        valid_sort = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", {31'd0, busy}, 0);
        checkOutput("reset_valid", {31'd0, valid_vote}, 0);
        checkOutput("reset_type", {29'd0, predicted_type}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] basic majority");
        applyStimulus(2, 2, 3, 2, 1, 5);
        runVote("basic", 3'd2, 3);

        $display("[TB] ties resolved by nearest first occurrence");
        applyStimulus(4, 3, 3, 4, 1, 0);
        runVote("tie_a", 3'd4, 2);
        applyStimulus(3, 4, 4, 3, 1, 0);
        runVote("tie_b", 3'd3, 2);

        $display("[TB] entries beyond K ignored");
        applyStimulus(5, 5, 5, 1, 1, 1);
        runVote("only_k", 3'd5, 3);

        $display("[TB] level held high");
        applyStimulus(6, 6, 1, 6, 7, 2);
        @(negedge clk);
        valid_sort = 1'b1;
        countPulses(40, pulses, seen);
        checkOutput("level_pulses", pulses, 1);
        checkOutput("level_type", {29'd0, seen}, 6);
        @(negedge clk);
        valid_sort = 1'b0;
        @(negedge clk);
        runVote("level_again", 3'd6, 3);

        $display("[TB] rising edge during COUNT");
        applyStimulus(2, 2, 3, 2, 1, 5);
        @(negedge clk);
        valid_sort = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        valid_sort = 1'b0;
        @(negedge clk);
        applyStimulus(5, 5, 5, 1, 1, 1);
        valid_sort = 1'b1;
        countPulses(30, pulses, seen);
        checkOutput("count_edge_pulses", pulses, 1);
        checkOutput("count_edge_type", {29'd0, seen}, 2);
        @(negedge clk);
        valid_sort = 1'b0;
        @(negedge clk);

        $display("[TB] reset during SELECT");
        applyStimulus(3, 3, 6, 6, 3, 0);
        @(negedge clk);
        valid_sort = 1'b1;
        @(posedge clk);
        repeat (7) @(posedge clk);
        #1;
        checkOutput("abort_busy_before", {31'd0, busy}, 1);
        rst = 1'b1;
        #1;
        checkOutput("abort_busy", {31'd0, busy}, 0);
        checkOutput("abort_type", {29'd0, predicted_type}, 0);
        checkOutput("abort_valid", {31'd0, valid_vote}, 0);
        applyStimulus(0, 0, 0, 1, 1, 7);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        waitResult("after_reset", 3'd0, 3);
        @(negedge clk);
        valid_sort = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/knn_vote.md
Name: knn_vote

Overview:
- Downstream stage of distance_sort in the KNN classifier datapath.
- Consumes the sorted type array and examines the K nearest entries (indices 0..K-1).
- Counts occurrences of each class, then selects the majority class sequentially.
- Emits the predicted class with a one-cycle valid strobe. This is the final classification result of the KNN_system pipeline.

Parameters:
- L, 5, log2 of the number of sorted entries (N = 2^L).
- TYPE_W, 3, class label width (T = 2^TYPE_W classes).
- K, 5, number of nearest neighbours voted; legal range 1 <= K <= 2^L, checked at elaboration.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- valid_sort  input  1  level from distance_sort; high while the sorted array is valid.
- type_array_sorted  input  TYPE_W*2^L  entry i at bits [(i+1)*TYPE_W-1 -: TYPE_W]; i=0 is the nearest.
- predicted_type  output  TYPE_W  winning class; held until the next result.
- valid_vote  output  1  one-cycle pulse when predicted_type updates.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: all registers and outputs go to 0; state goes to IDLE; valid_sort_q goes to 0.
- Start condition: start = valid_sort & ~valid_sort_q, evaluated in IDLE only.
  - valid_sort_q is a register updated every cycle.
  - If valid_sort is already high when rst deasserts, exactly one start fires.
  - A rising edge outside IDLE is dropped (no queueing, no side effect).
- State: IDLE.
  - On start: latch entries 0..K-1 into a local type register.
  - Clear count[0..T-1] and set first_pos[0..T-1] = K.
  - Set idx = 0, busy = 1, then go to COUNT.
- State: COUNT, one entry per cycle.
  - t = latched[idx]; count[t] += 1.
  - If first_pos[t] == K, set first_pos[t] = idx.
  - After idx = K-1, go to SELECT.
  - Count width CW = $clog2(K+1); saturation is never reached since the total is K.
- State: SELECT, one class per cycle, c = 0..T-1.
  - Initialise best_count = 0, best_type = 0, best_pos = K.
  - c replaces the best if count[c] > best_count, or if count[c] == best_count, count[c] != 0 and first_pos[c] < best_pos.
  - Tie rule: among classes with equal counts, the class whose first occurrence is nearest wins.
  - After c = T-1, go to DONE.
- State: DONE.
  - Register predicted_type = best_type and valid_vote = 1 for exactly one cycle.
  - Return to IDLE; busy drops in the same cycle valid_vote is high.
- Latency: valid_vote is high in the cycle following clock edge K + T + 1 counted from the edge that sampled start (14 edges for the defaults).
- Type 0 is an ordinary class; no class is reserved.
- Reset mid-operation: immediate abort and return to reset values; no valid_vote; predicted_type is cleared to 0.
- Entries at indices >= K never influence the result.

Optional Feature:
- Macro: KNN_VOTE_COUNT_OUT_EN.
- Defined: adds output port vote_count [CW-1:0], the winning class's count.
  - Registered alongside predicted_type; reset 0; held between results.
- Undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Shared package knn_pkg:
  - State enum: IDLE, COUNT, SELECT, DONE.
  - Default TYPE_W and L constants.
  - Helper function computing CW from K.
  - distance_sort adopts TYPE_W from the same package.
- One natural sub-module, knn_type_counter.
  - Holds the count[] and first_pos[] banks with clear/increment and a read port indexed by c.
  - The top level keeps the FSM, start detect and best tracking.

Test Plan:
- Basic majority (K=5, TYPE_W=3): types[0..4] = 2,2,3,2,1, rest 5 → predicted_type=2 and vote_count=3 after 14 edges; valid_vote high for exactly 1 cycle.
- Tie: types[0..4] = 4,3,3,4,1 → predicted_type=4 (counts 2-2, class 4 first at index 0); then 3,4,4,3,1 → predicted_type=3.
- Only K entries used: types[0..4] = 5,5,5,1,1 and indices 5..31 all 1 → predicted_type=5, vote_count=3.
- Level handling: valid_sort held high for 40 cycles → exactly one valid_vote; drop valid_sort then raise it again → second result.
- Rising edge of valid_sort during COUNT is ignored → a single valid_vote for the first array.
- Reset mid-operation: rst pulsed during SELECT → busy=0, predicted_type=0, no valid_vote; the next start with types 0,0,0,1,1 → predicted_type=0, vote_count=3.
